// File: rtl/bsg_cycle_stamp_fifo.sv
// bsg_cycle_stamp_fifo
//   Captures the free-running cycle count (ctr_i) on every event pulse and
//   buffers the stamps in a small power-of-two FIFO drained over valid/yumi.
//   Events that arrive while the FIFO is full (and no pop happens that cycle)
//   are dropped and counted in a saturating counter.
//
//   Optional build macro: BSG_CYCLE_STAMP_FIFO_DELTA_EN
//     When defined, each entry also stores (stamp - previous accepted stamp)
//     mod 2^width_p, presented on delta_o for the head entry.
//
// Ports
//   clk_i         rising-edge clock
//   reset_n_i     asynchronous active-low reset
//   ctr_i         cycle count from the upstream counter
//   event_v_i     event pulse, one stamp request per high cycle
//   v_o           head entry valid
//   data_o        head stamp, 0 when v_o=0
//   yumi_i        consumer pops the head (legal only when v_o=1)
//   full_o        FIFO holds els_p entries
//   drop_count_o  saturating count of dropped events
//   delta_o       (macro only) head delta, 0 when v_o=0
module bsg_cycle_stamp_fifo #(
  parameter int width_p      = 32,
  parameter int els_p        = 4,
  parameter int drop_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      ctr_i,
  input  logic                    event_v_i,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    yumi_i,
  output logic                    full_o,
  output logic [drop_width_p-1:0] drop_count_o
`ifdef BSG_CYCLE_STAMP_FIFO_DELTA_EN
  ,
  output logic [width_p-1:0]      delta_o
`endif
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] els_cnt = cnt_w'(els_p);
  localparam logic [cnt_w-1:0] one_cnt = cnt_w'(1);
  localparam logic [ptr_w-1:0] one_ptr = ptr_w'(1);

  function automatic logic [drop_width_p-1:0] sat_inc(input logic [drop_width_p-1:0] x);
    return (&x) ? x : x + drop_width_p'(1);
  endfunction

  logic [ptr_w-1:0]        wptr_r, rptr_r;
  logic [cnt_w-1:0]        count_r;
  logic [drop_width_p-1:0] drop_r;
  logic [width_p-1:0]      mem [els_p];

  logic pop, push, drop;

  // Status comes purely from registered occupancy; no input-to-output paths.
  assign v_o    = (count_r != '0);
  assign full_o = (count_r == els_cnt);

  // A pop at full frees a slot in the same edge, so the event is still accepted.
  assign pop  = yumi_i & v_o;
  assign push = event_v_i & (~full_o | pop);
  assign drop = event_v_i & full_o & ~pop;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      drop_r  <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + one_ptr;
      if (pop)  rptr_r <= rptr_r + one_ptr;
      case ({push, pop})
        2'b10:   count_r <= count_r + one_cnt;
        2'b01:   count_r <= count_r - one_cnt;
        default: count_r <= count_r;
      endcase
      if (drop) drop_r <= sat_inc(drop_r);
    end
  end

  assign drop_count_o = drop_r;
  assign data_o       = v_o ? mem[rptr_r] : '0;

`ifdef BSG_CYCLE_STAMP_FIFO_DELTA_EN
  logic [width_p-1:0] delta_mem [els_p];
  logic [width_p-1:0] prev_r;

  // Only accepted stamps advance the delta base; drops leave it alone.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) prev_r <= '0;
    else if (push)  prev_r <= ctr_i;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_r]       <= ctr_i;
      delta_mem[wptr_r] <= ctr_i - prev_r;
    end
  end

  assign delta_o = v_o ? delta_mem[rptr_r] : '0;
`else
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_r] <= ctr_i;
  end
`endif

`ifndef SYNTHESIS
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o=0");
`endif

endmodule
